// File: rtl/mem_port_arbiter_pkg.sv
// mem_arb_defs: shared encodings for the memory port arbiter
package mem_arb_defs;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;
  localparam logic OP_READ = 1'b0;
  localparam logic OP_WRITE = 1'b1;
  localparam int MAX_PORTS = 8;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: requester and memory side signals of the arbiter
interface mem_port_arbiter_if #(
  parameter int N_PORTS = 2,
  parameter int ADDR_W = 6,
  parameter int DATA_W = 128
);
  logic [N_PORTS-1:0] req_read;
  logic [N_PORTS-1:0] req_write;
  logic [N_PORTS*ADDR_W-1:0] req_address;
  logic [N_PORTS*DATA_W-1:0] req_writedata;
  logic [DATA_W-1:0] req_readdata;
  logic [N_PORTS-1:0] req_busywait;
  logic mem_read;
  logic mem_write;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_writedata;
  logic [DATA_W-1:0] mem_readdata;
  logic mem_busywait;
  modport slave (
    input req_read, req_write, req_address, req_writedata, mem_readdata, mem_busywait,
    output req_readdata, req_busywait, mem_read, mem_write, mem_address, mem_writedata
  );
  modport master (
    output req_read, req_write, req_address, req_writedata, mem_readdata, mem_busywait,
    input req_readdata, req_busywait, mem_read, mem_write, mem_address, mem_writedata
  );
endinterface

// File: rtl/mem_port_arbiter_rr_picker.sv
// rr_picker: first pending port at or after ptr, wrapping modulo n_ports
module rr_picker #(
  parameter int N_PORTS = 2,
  localparam int IW = $clog2(N_PORTS)
) (
  input  logic [N_PORTS-1:0] pending,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] winner,
  output logic any_valid
);
  logic [IW-1:0] idx;
  assign any_valid = |pending;
  // scan farthest first so the port closest to ptr overwrites last
  always_comb begin
    winner = '0;
    idx = '0;
    for (int k = N_PORTS - 1; k >= 0; k--) begin
      idx = IW'((int'(ptr) + k) % N_PORTS);
      winner = pending[idx] ? idx : winner;
    end
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin sharing of one backing memory among n cache ports
module mem_port_arbiter
  import mem_arb_defs::*;
#(
  parameter int N_PORTS = 2,
  parameter int ADDR_W = 6,
  parameter int DATA_W = 128
) (
  input logic clk,
  input logic reset,
  mem_port_arbiter_if.slave bus
);
  localparam int IW = $clog2(N_PORTS);
  logic [1:0] state, next_state;
  logic [IW-1:0] ptr, grant, winner;
  logic any_valid, op, op_nxt, strobe_nxt;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata, rdata;
  logic [N_PORTS-1:0] pending;
  assign pending = bus.req_read | bus.req_write;
  rr_picker #(.N_PORTS(N_PORTS)) u_picker (
    .pending(pending),
    .ptr(ptr),
    .winner(winner),
    .any_valid(any_valid)
  );
  always_ff @(posedge clk) begin
    if (!reset) state <= S_IDLE;
    else state <= next_state;
  end
  always_comb begin
    next_state = state == S_IDLE ? (any_valid ? S_ISSUE : S_IDLE) :
                 state == S_ISSUE ? S_WAIT :
                 state == S_WAIT ? (bus.mem_busywait ? S_WAIT : S_RESP) : S_IDLE;
    op_nxt = state == S_IDLE ? bus.req_write[winner] : op;
    strobe_nxt = next_state == S_ISSUE || next_state == S_WAIT;
  end
  // write wins when a port raises both; strobes are flopped from the next state
  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr <= '0;
      grant <= '0;
      op <= OP_READ;
      addr <= '0;
      wdata <= '0;
      rdata <= '0;
      bus.mem_read <= 1'b0;
      bus.mem_write <= 1'b0;
    end else begin
      if (state == S_IDLE && any_valid) begin
        grant <= winner;
        op <= bus.req_write[winner];
        addr <= bus.req_address[winner*ADDR_W +: ADDR_W];
        wdata <= bus.req_writedata[winner*DATA_W +: DATA_W];
      end
      if (state == S_WAIT && !bus.mem_busywait && op == OP_READ) rdata <= bus.mem_readdata;
      if (state == S_RESP) ptr <= grant == IW'(N_PORTS - 1) ? '0 : grant + 1'b1;
      bus.mem_read <= strobe_nxt && op_nxt == OP_READ;
      bus.mem_write <= strobe_nxt && op_nxt == OP_WRITE;
    end
  end
  assign bus.mem_address = addr;
  assign bus.mem_writedata = wdata;
  assign bus.req_readdata = rdata;
  always_comb begin
    bus.req_busywait = pending;
    for (int i = 0; i < N_PORTS; i++)
      bus.req_busywait[i] = (state == S_RESP && grant == IW'(i)) ? 1'b0 : pending[i];
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of a 2-port and a 4-port arbiter
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic reset;
  int n_tests = 0, n_fail = 0;
  int k2, k4, cnt2, cnt4, nrd2, nwr2;
  logic was2 = 1'b0;
  logic [5:0] waddr2;
  logic [127:0] wdat2;
  logic [5:0] log2[$];
  always #5 clk = ~clk;
  mem_port_arbiter_if #(.N_PORTS(2), .ADDR_W(6), .DATA_W(128)) b2 ();
  mem_port_arbiter_if #(.N_PORTS(4), .ADDR_W(6), .DATA_W(128)) b4 ();
  mem_port_arbiter #(.N_PORTS(2), .ADDR_W(6), .DATA_W(128)) u2 (.clk(clk), .reset(reset), .bus(b2));
  mem_port_arbiter #(.N_PORTS(4), .ADDR_W(6), .DATA_W(128)) u4 (.clk(clk), .reset(reset), .bus(b4));
  function automatic logic [127:0] exp_rd(input logic [5:0] a);
    return {32'hDEADBEEF, 32'hCAFEF00D, 58'h0, a};
  endfunction
  // memory models: busy for k cycles after a strobe appears, data derived from address
  always @(posedge clk) cnt2 <= (!reset || !(b2.mem_read || b2.mem_write)) ? k2 : (cnt2 != 0 ? cnt2 - 1 : 0);
  always @(posedge clk) cnt4 <= (!reset || !(b4.mem_read || b4.mem_write)) ? k4 : (cnt4 != 0 ? cnt4 - 1 : 0);
  assign b2.mem_busywait = (b2.mem_read || b2.mem_write) && cnt2 != 0;
  assign b4.mem_busywait = (b4.mem_read || b4.mem_write) && cnt4 != 0;
  assign b2.mem_readdata = exp_rd(b2.mem_address);
  assign b4.mem_readdata = exp_rd(b4.mem_address);
  always @(posedge clk) begin
    #2;
    if ((b2.mem_read || b2.mem_write) && !was2) begin
      log2.push_back(b2.mem_address);
      if (b2.mem_read) nrd2++;
      if (b2.mem_write) begin
        nwr2++;
        waddr2 = b2.mem_address;
        wdat2 = b2.mem_writedata;
      end
    end
    was2 = b2.mem_read || b2.mem_write;
  end
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask
  task automatic set2(input int p, input logic [5:0] a);
    b2.req_address[p*6 +: 6] = a;
  endtask
  task automatic wait_free2(input int p, input string tag);
    logic ok = 1'b0;
    for (int c = 0; c < 100 && !ok; c++) begin
      @(negedge clk);
      ok = !b2.req_busywait[p];
    end
    check({tag, "_done"}, ok, 1'b1);
  endtask
  task automatic wait_strobe2(input string tag);
    logic ok = 1'b0;
    for (int c = 0; c < 100 && !ok; c++) begin
      @(negedge clk);
      ok = b2.mem_read || b2.mem_write;
    end
    check({tag, "_strobe"}, ok, 1'b1);
  endtask
  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end
  initial begin
    logic seen, bad0, ok;
    int served;
    int order[$];
    reset = 1'b0;
    k2 = 5;
    k4 = 3;
    b2.req_read = '0; b2.req_write = '0; b2.req_address = '0; b2.req_writedata = '0;
    b4.req_read = '0; b4.req_write = '0; b4.req_address = '0; b4.req_writedata = '0;
    repeat (2) @(negedge clk);
    b2.req_read[0] = 1'b1;
    #1;
    check("rst_busywait_follows", b2.req_busywait[0], 1'b1);
    check("rst_mem_read", b2.mem_read, 1'b0);
    check("rst_mem_write", b2.mem_write, 1'b0);
    check("rst_mem_address", b2.mem_address, 6'h0);
    check("rst_mem_writedata", b2.mem_writedata, 128'h0);
    check("rst_req_readdata", b2.req_readdata, 128'h0);
    b2.req_read[0] = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    // single read on port 1
    set2(1, 6'h2A);
    b2.req_read[1] = 1'b1;
    #1;
    check("t1_stall_same_cycle", b2.req_busywait[1], 1'b1);
    seen = 1'b0; bad0 = 1'b0; ok = 1'b0;
    for (int c = 0; c < 100 && !ok; c++) begin
      @(negedge clk);
      if (b2.req_busywait[0]) bad0 = 1'b1;
      if (b2.mem_read && !seen) begin
        seen = 1'b1;
        check("t1_mem_address", b2.mem_address, 6'h2A);
      end
      ok = !b2.req_busywait[1];
    end
    check("t1_done", ok, 1'b1);
    check("t1_read_seen", seen, 1'b1);
    check("t1_rdata", b2.req_readdata, exp_rd(6'h2A));
    check("t1_strobe_low_resp", b2.mem_read, 1'b0);
    check("t1_port0_no_stall", bad0, 1'b0);
    b2.req_read[1] = 1'b0;
    // simultaneous requests after reset
    @(negedge clk) reset = 1'b0;
    @(negedge clk) reset = 1'b1;
    log2.delete();
    set2(0, 6'h05); set2(1, 6'h09);
    b2.req_read = 2'b11;
    wait_free2(0, "t2_p0");
    check("t2_p0_rdata", b2.req_readdata, exp_rd(6'h05));
    check("t2_p1_still_stalled", b2.req_busywait[1], 1'b1);
    set2(0, 6'h06);
    wait_free2(1, "t2_p1");
    check("t2_p1_rdata", b2.req_readdata, exp_rd(6'h09));
    b2.req_read[1] = 1'b0;
    wait_free2(0, "t2_p0b");
    check("t2_p0b_rdata", b2.req_readdata, exp_rd(6'h06));
    b2.req_read[0] = 1'b0;
    check("t2_grants", log2.size(), 3);
    check("t2_first", log2[0], 6'h05);
    check("t2_second", log2[1], 6'h09);
    check("t2_third", log2[2], 6'h06);
    // read and write both high: treated as write
    log2.delete();
    nrd2 = 0; nwr2 = 0;
    set2(0, 6'h11);
    b2.req_writedata[127:0] = {16{8'h55}};
    b2.req_read[0] = 1'b1; b2.req_write[0] = 1'b1;
    wait_free2(0, "t3");
    b2.req_read[0] = 1'b0; b2.req_write[0] = 1'b0;
    check("t3_no_read", nrd2, 0);
    check("t3_one_write", nwr2, 1);
    check("t3_waddr", waddr2, 6'h11);
    check("t3_wdata", wdat2, {16{8'h55}});
    // withdrawal mid-transaction, payload frozen at grant
    k2 = 8;
    set2(1, 6'h20);
    b2.req_read[1] = 1'b1;
    wait_strobe2("t4");
    repeat (2) @(negedge clk);
    b2.req_read[1] = 1'b0;
    set2(1, 6'h3F);
    #1;
    check("t4_no_stall_after_drop", b2.req_busywait[1], 1'b0);
    check("t4_read_held", b2.mem_read, 1'b1);
    check("t4_addr_frozen", b2.mem_address, 6'h20);
    ok = 1'b0;
    for (int c = 0; c < 100 && !ok; c++) begin
      @(negedge clk);
      ok = !b2.mem_read;
    end
    check("t4_completes", ok, 1'b1);
    log2.delete();
    set2(0, 6'h01); set2(1, 6'h02);
    b2.req_read = 2'b11;
    wait_free2(0, "t4_p0");
    check("t4_ptr_advanced", log2[0], 6'h01);
    b2.req_read[0] = 1'b0;
    wait_free2(1, "t4_p1");
    check("t4_p1_rdata", b2.req_readdata, exp_rd(6'h02));
    b2.req_read[1] = 1'b0;
    // reset mid-WAIT with ptr pointing at port 1
    set2(0, 6'h30);
    b2.req_read[0] = 1'b1;
    wait_free2(0, "t5_pre");
    b2.req_read[0] = 1'b0;
    set2(1, 6'h33);
    b2.req_read[1] = 1'b1;
    wait_strobe2("t5");
    repeat (2) @(negedge clk);
    b2.req_read[0] = 1'b1;
    reset = 1'b0;
    @(negedge clk) reset = 1'b1;
    check("t5_read_cleared", b2.mem_read, 1'b0);
    check("t5_addr_cleared", b2.mem_address, 6'h0);
    @(negedge clk);
    check("t5_regrant", b2.mem_read, 1'b1);
    check("t5_ptr_cleared", b2.mem_address, 6'h30);
    wait_free2(0, "t5_p0");
    check("t5_p0_rdata", b2.req_readdata, exp_rd(6'h30));
    b2.req_read[0] = 1'b0;
    wait_free2(1, "t5_p1");
    check("t5_p1_rdata", b2.req_readdata, exp_rd(6'h33));
    b2.req_read[1] = 1'b0;
    // fairness with four ports requesting continuously
    for (int p = 0; p < 4; p++) b4.req_address[p*6 +: 6] = 6'(16 + p);
    b4.req_read = 4'hF;
    served = 0;
    for (int c = 0; c < 400 && served < 5; c++) begin
      @(negedge clk);
      for (int p = 0; p < 4; p++)
        if (!b4.req_busywait[p]) begin
          check("t6_rdata", b4.req_readdata, exp_rd(6'(16 + p)));
          order.push_back(p);
          served++;
        end
    end
    b4.req_read = '0;
    check("t6_served", served, 5);
    for (int i = 0; i < 5; i++) check("t6_order", order[i], i % 4);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
